// File: rtl/reg_bank_16_if.sv
// Bus interface for reg_bank_16: two read ports, one write port, R15 (PC+8)
// substitution input, clear-sweep control and status.
//   A1, A2    : read addresses          RD1, RD2 : read data (combinational)
//   A3, WD3   : write address / data    WE3      : write enable
//   R15_In    : value returned for R15  ClrStart : pulse to start clear sweep
//   Busy      : clear sweep running     WrErr    : sticky write-to-R15 flag
interface reg_bank_16_if #(
  parameter int unsigned W = 32
);
  logic [3:0]   A1;
  logic [3:0]   A2;
  logic [3:0]   A3;
  logic [W-1:0] WD3;
  logic         WE3;
  logic [W-1:0] R15_In;
  logic         ClrStart;
  logic [W-1:0] RD1;
  logic [W-1:0] RD2;
  logic         Busy;
  logic         WrErr;

  modport master (
    output A1, A2, A3, WD3, WE3, R15_In, ClrStart,
    input  RD1, RD2, Busy, WrErr
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, R15_In, ClrStart,
    output RD1, RD2, Busy, WrErr
  );
endinterface

// File: rtl/reg_bank_16.sv
// reg_bank_16: 16-entry register bank (R0..R14 stored, R15 = R15_In) with
// two combinational read ports, one write port and a clear sweeper that
// zeroes R0..R14 one register per cycle.
// Ports:
//   CLK     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : reg_bank_16_if.slave (addresses, data, control, status)
// Parameters: W (data width), CLR_VAL (value written by the sweeper).
// Build option: define WRITE_BYPASS_EN to forward WD3 to a read port whose
// address matches an accepted write in the same cycle.

// 16:1 read-select mux.
module Mux16x1 #(
  parameter int unsigned W = 32
) (
  input  logic [15:0][W-1:0] d,
  input  logic [3:0]         sel,
  output logic [W-1:0]       y
);
  assign y = d[sel];
endmodule

module reg_bank_16 #(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic          CLK,
  input  logic          Reset_n,
  reg_bank_16_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [W-1:0]      regs [15];
  logic              wr_err_q;
  logic              busy;
  logic [15:0][W-1:0] mux_in;
  logic [W-1:0]      rd1_raw;
  logic [W-1:0]      rd2_raw;

  assign busy = (state_q == SWEEP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ClrStart) state_d = SWEEP;
      SWEEP:   if (cnt_q == 4'd14) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Writes are only accepted while idle; a write issued in the same cycle as
  // ClrStart commits now and is overwritten by the sweep afterwards.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < 15; i++) regs[i] <= '0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (bus.WE3 && (bus.A3 == 4'hF)) wr_err_q <= 1'b1;
      if (state_q == SWEEP) begin
        regs[cnt_q] <= CLR_VAL;
        cnt_q       <= cnt_q + 4'd1;
      end else begin
        if (bus.ClrStart) cnt_q <= '0;
        if (bus.WE3 && (bus.A3 != 4'hF)) regs[bus.A3] <= bus.WD3;
      end
    end
  end

  always_comb begin
    mux_in = '0;
    for (int unsigned i = 0; i < 15; i++) mux_in[i] = regs[i];
    mux_in[15] = bus.R15_In;
  end

  Mux16x1 #(.W(W)) u_mux1 (.d(mux_in), .sel(bus.A1), .y(rd1_raw));
  Mux16x1 #(.W(W)) u_mux2 (.d(mux_in), .sel(bus.A2), .y(rd2_raw));

`ifdef WRITE_BYPASS_EN
  logic wr_fwd;
  assign wr_fwd  = bus.WE3 && !busy && (bus.A3 != 4'hF);
  assign bus.RD1 = (wr_fwd && (bus.A1 == bus.A3)) ? bus.WD3 : rd1_raw;
  assign bus.RD2 = (wr_fwd && (bus.A2 == bus.A3)) ? bus.WD3 : rd2_raw;
`else
  assign bus.RD1 = rd1_raw;
  assign bus.RD2 = rd2_raw;
`endif

  assign bus.Busy  = busy;
  assign bus.WrErr = wr_err_q;

endmodule
